// File: rtl/alu_seq.sv
// Registered W-bit ALU: one operation per start pulse, results and flags held in output registers.
// Define ALU_SEQ_MUL_EN to build the multi-cycle shift-add multiplier (op 110); otherwise 110 is reserved.
module alu_seq #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [2:0]   ALUop,
    input  logic [W-1:0] Ain,
    input  logic [W-1:0] Bin,
    output logic [W-1:0] out,
    output logic         Z,
    output logic         N,
    output logic         V,
    output logic         busy,
    output logic         done
);

    // Single-cycle result in the low W bits, overflow flag on top; 110 and 111 yield zero here.
    function automatic logic [W:0] alu_calc(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic         v;
        r = {W{1'b0}};
        v = 1'b0;
        case (op)
            3'b000: begin
                r = a + b;
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b001: begin
                r = a - b;
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            3'b010:  r = a & b;
            3'b011:  r = ~b;
            3'b100:  r = a | b;
            3'b101:  r = a ^ b;
            default: r = {W{1'b0}};
        endcase
        return {v, r};
    endfunction

    logic [W:0]   calc_s;
    logic         load_s;
    logic         busy_s;
    logic [W-1:0] new_out_s;
    logic         new_v_s;

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [W-1:0]   mcand_r;
    logic [W-1:0]   mplier_r;
    logic [2*W-1:0] acc_r;
    logic [2*W-1:0] acc_s;
    logic [CW-1:0]  cnt_r;
    logic           mul_go_s;
`endif

    // Next-state, completion and result selection.
    always_comb begin
        calc_s    = alu_calc(ALUop, Ain, Bin);
        load_s    = 1'b0;
        busy_s    = 1'b0;
        new_out_s = calc_s[W-1:0];
        new_v_s   = calc_s[W];
`ifdef ALU_SEQ_MUL_EN
        state_s  = state_r;
        mul_go_s = 1'b0;
        acc_s    = acc_r + (mplier_r[cnt_r] ? ({{W{1'b0}}, mcand_r} << cnt_r) : {(2*W){1'b0}});
        case (state_r)
            ST_IDLE: begin
                if (start && (ALUop == 3'b110)) begin
                    mul_go_s = 1'b1;
                    state_s  = ST_MUL;
                end else if (start) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_MUL: begin
                // The final partial product is folded in combinationally so the result lands on this edge.
                if (cnt_r == CW'(W - 1)) begin
                    state_s   = ST_IDLE;
                    load_s    = 1'b1;
                    new_out_s = acc_s[W-1:0];
                    new_v_s   = |acc_s[2*W-1:W];
                end else begin
                    state_s = ST_MUL;
                end
            end
            default: state_s = ST_IDLE;
        endcase
        busy_s = (state_s == ST_MUL);
`else
        if (start) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
`endif
    end

`ifdef ALU_SEQ_MUL_EN
    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Multiplier operand latches, accumulator and step counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (mul_go_s) begin
            mcand_r  <= Ain;
            mplier_r <= Bin;
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (state_r == ST_MUL) begin
            acc_r <= acc_s;
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            acc_r <= acc_r;
            cnt_r <= cnt_r;
        end
    end
`endif

    // Output registers: result and flags update only on a completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out  <= {W{1'b0}};
            Z    <= 1'b0;
            N    <= 1'b0;
            V    <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= load_s;
            if (load_s) begin
                out <= new_out_s;
                Z   <= (new_out_s == {W{1'b0}});
                N   <= new_out_s[W-1];
                V   <= new_v_s;
            end
        end
    end

endmodule
